// File: rtl/pwm_scheduler.sv
// pwm_scheduler
//   Drives 16 channel outputs from the SPI-written configuration: output
//   enables, PWM selects and one shared duty value. A prescaled 8-bit period
//   counter generates the PWM. Each channel can take a fixed phase offset so
//   that switching edges are spread out. All configuration goes through shadow
//   registers that load only at a period boundary. An SPI write therefore
//   never truncates or stretches a pulse.
//
// Parameters
//   PRESCALE    clk cycles per PWM counter tick (1..65535)
//   PHASE_STEP  per-channel counter offset; channel i uses (i*PHASE_STEP) mod 256
//
// Ports
//   clk              system clock (same domain as the SPI register file)
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, channels 7..0
//   en_reg_out_15_8  output enable, channels 15..8
//   en_reg_pwm_7_0   PWM select, channels 7..0
//   en_reg_pwm_15_8  PWM select, channels 15..8
//   pwm_duty_cycle   shared duty; 0x00 = always low, 0xFF = always high
//   out              registered channel outputs, bit i = channel i
//   period_start     one-cycle pulse in the cycle the global counter reads 0
//                    after a wrap
module pwm_scheduler #(
  parameter int unsigned PRESCALE   = 3000,
  parameter int unsigned PHASE_STEP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre;
  logic        tick;
  logic [7:0]  cnt;
  logic        wrap;
  logic        init;
  logic        load;

  logic [15:0] sh_en_out;
  logic [15:0] sh_en_pwm;
  logic [7:0]  sh_duty;

  logic [7:0]  ccnt [16];
  logic [15:0] pwm_lvl;
  logic [15:0] out_next;

  // With PRESCALE = 1, PRE_LAST is 0 and pre never leaves 0, so tick stays high.
  assign tick = (pre == PRE_LAST);
  assign wrap = tick && (cnt == 8'hFF);

  // init loads the shadows on the first edge after reset release. This makes
  // the configuration live without waiting a full period after power-up.
  assign load = wrap || init;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init <= 1'b1;
    end else begin
      init <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en_out <= '0;
      sh_en_pwm <= '0;
      sh_duty   <= '0;
    end else if (load) begin
      sh_en_out <= {en_reg_out_15_8, en_reg_out_7_0};
      sh_en_pwm <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
      sh_duty   <= pwm_duty_cycle;
    end
  end

  // The phase offsets are elaboration-time constants. Each channel needs
  // only one 8-bit adder, and that adder wraps naturally.
  for (genvar g = 0; g < 16; g++) begin : g_phase
    localparam logic [7:0] PHASE_OFS = 8'((g * PHASE_STEP) % 256);
    assign ccnt[g] = cnt + PHASE_OFS;
  end

  always_comb begin
    pwm_lvl  = '0;
    out_next = '0;
    for (int i = 0; i < 16; i++) begin
      // 0xFF is forced fully high. Without this, the ccnt = 255 slot would
      // produce a one-tick low.
      pwm_lvl[i]  = (sh_duty == 8'hFF) || (ccnt[i] < sh_duty);
      out_next[i] = sh_en_out[i] && (!sh_en_pwm[i] || pwm_lvl[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_scheduler.sv
// Bench for pwm_scheduler.
//   dut_a: PRESCALE = 1, PHASE_STEP = 0
//          (init load, duty, extremes, shadowing, mid-period reset)
//   dut_b: PRESCALE = 4, PHASE_STEP = 16
//          (prescaler and phase stagger)
module tb_pwm_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] en_out_a = '0;
  logic [15:0] en_pwm_a = '0;
  logic [7:0]  duty_a = '0;
  logic [15:0] out_a;
  logic        ps_a;

  logic [15:0] en_out_b = 16'hFFFF;
  logic [15:0] en_pwm_b = 16'hFFFF;
  logic [7:0]  duty_b = 8'h80;
  logic [15:0] out_b;
  logic        ps_b;

  always #5 clk = ~clk;

  pwm_scheduler #(.PRESCALE(1), .PHASE_STEP(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_a[7:0]), .en_reg_out_15_8(en_out_a[15:8]),
    .en_reg_pwm_7_0(en_pwm_a[7:0]), .en_reg_pwm_15_8(en_pwm_a[15:8]),
    .pwm_duty_cycle(duty_a), .out(out_a), .period_start(ps_a)
  );

  pwm_scheduler #(.PRESCALE(4), .PHASE_STEP(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(en_out_b[7:0]), .en_reg_out_15_8(en_out_b[15:8]),
    .en_reg_pwm_7_0(en_pwm_b[7:0]), .en_reg_pwm_15_8(en_pwm_b[15:8]),
    .pwm_duty_cycle(duty_b), .out(out_b), .period_start(ps_b)
  );

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    int          exp0;
    int          exp7;
    int          exp15;
  } vec_t;

  vec_t vecs [6];

  int n_cmp = 0;
  int n_err = 0;

  int   hi_a [16];
  int   ps_cnt_a;
  logic first_a;
  logic last_a;

  int   hi_b [16];
  int   rise_b [16];
  int   ps_cnt_b;
  logic prev_b [16];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Waits, with a bound, for the negedge at which dut_a's period_start is high.
  task automatic sync_a(input string name);
    bit seen = 0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (ps_a) seen = 1;
    end
    if (!seen) check(name, 0, 1);
  endtask

  task automatic sync_b(input string name);
    bit seen = 0;
    for (int k = 0; k < 2200 && !seen; k++) begin
      @(negedge clk);
      if (ps_b) seen = 1;
    end
    if (!seen) check(name, 0, 1);
  endtask

  // Call this at the period_start negedge. It samples the 256 following cycles.
  // Iteration i sees out for cnt = i. Iteration 255 is the next period_start.
  // When i == change_at, the duty input is rewritten after that sample.
  task automatic run_period_a(input int change_at, input logic [7:0] new_duty);
    for (int c = 0; c < 16; c++) hi_a[c] = 0;
    ps_cnt_a = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      for (int c = 0; c < 16; c++) if (out_a[c]) hi_a[c]++;
      if (ps_a) ps_cnt_a++;
      if (i == 0) first_a = out_a[0];
      if (i == 255) last_a = out_a[0];
      if (i == change_at) duty_a = new_duty;
    end
  endtask

  initial begin
    int n;
    bit seen;

    vecs[0] = '{16'hFFFF, 16'h0000, 8'h00, 256, 256, 256};
    vecs[1] = '{16'h0001, 16'h0001, 8'h40,  64,   0,   0};
    vecs[2] = '{16'h8081, 16'h8001, 8'h00,   0, 256,   0};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 256, 256, 256};
    vecs[4] = '{16'h7F80, 16'h00FF, 8'hC0,   0, 192,   0};
    vecs[5] = '{16'h8001, 16'h8000, 8'h01, 256,   0,   1};

    // Reset, then the init load.
    en_out_a = 16'hFFFF;
    en_pwm_a = 16'h0000;
    duty_a   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_out", int'(out_a), 0);
    check("reset_ps", int'(ps_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_edge1_out", int'(out_a), 0);
    @(negedge clk);
    check("init_edge2_out", int'(out_a), 16'hFFFF);

    // Table-driven configurations over one full period each.
    for (int v = 0; v < 6; v++) begin
      en_out_a = vecs[v].en_out;
      en_pwm_a = vecs[v].en_pwm;
      duty_a   = vecs[v].duty;
      sync_a($sformatf("vec%0d_sync", v));
      run_period_a(-1, 8'h00);
      check($sformatf("vec%0d_ch0_high", v), hi_a[0], vecs[v].exp0);
      check($sformatf("vec%0d_ch7_high", v), hi_a[7], vecs[v].exp7);
      check($sformatf("vec%0d_ch15_high", v), hi_a[15], vecs[v].exp15);
      check($sformatf("vec%0d_period_start", v), ps_cnt_a, 1);
    end

    // Shadowing: a mid-period change, a change on the wrap cycle, and a
    // change on the cycle after the wrap.
    en_out_a = 16'h0001;
    en_pwm_a = 16'h0001;
    duty_a   = 8'h40;
    sync_a("shadow_sync");
    run_period_a(99, 8'hC0);
    check("shadow_p1_high", hi_a[0], 64);
    check("shadow_p1_rise_after_ps", int'(first_a), 1);
    check("shadow_p1_low_at_ps", int'(last_a), 0);
    check("shadow_p1_ps", ps_cnt_a, 1);
    run_period_a(254, 8'h20);
    check("shadow_p2_high", hi_a[0], 192);
    run_period_a(255, 8'h80);
    check("shadow_wrapchg_high", hi_a[0], 32);
    run_period_a(-1, 8'h00);
    check("shadow_late_chg_waits", hi_a[0], 32);
    run_period_a(-1, 8'h00);
    check("shadow_late_chg_applies", hi_a[0], 128);

    // Reset at cnt = 37, with outputs active.
    en_out_a = 16'hFFFF;
    en_pwm_a = 16'h0001;
    duty_a   = 8'h40;
    sync_a("midrst_sync");
    sync_a("midrst_sync2");
    repeat (37) @(negedge clk);
    check("midrst_active_before", int'(out_a), 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_async", int'(out_a), 0);
    check("midrst_ps_async", int'(ps_a), 0);
    check("midrst_outb_async", int'(out_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_edge1_out", int'(out_a), 0);
    @(negedge clk);
    check("midrst_edge2_out", int'(out_a), 16'hFFFF);
    n = 2;
    seen = 0;
    while (n < 600 && !seen) begin
      @(negedge clk);
      n++;
      if (ps_a) seen = 1;
    end
    check("midrst_first_ps_cycle", n, 256);

    // Prescaler and phase stagger on dut_b.
    sync_b("phase_sync");
    for (int c = 0; c < 16; c++) begin
      hi_b[c]   = 0;
      rise_b[c] = -1;
      prev_b[c] = out_b[c];
    end
    ps_cnt_b = 0;
    for (int j = 0; j < 1024; j++) begin
      @(negedge clk);
      if (ps_b) ps_cnt_b++;
      for (int c = 0; c < 16; c++) begin
        if (out_b[c]) hi_b[c]++;
        if (out_b[c] && !prev_b[c] && rise_b[c] < 0) rise_b[c] = j;
        prev_b[c] = out_b[c];
      end
    end
    check("phase_period_start_count", ps_cnt_b, 1);
    check("phase_ps_at_1024", int'(ps_b), 1);
    for (int c = 0; c < 16; c++) begin
      check($sformatf("phase_ch%0d_high", c), hi_b[c], 512);
      check($sformatf("phase_ch%0d_rise", c), rise_b[c], (c == 0) ? 0 : 1024 - 64 * c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
